// File: rtl/canvas_port_arbiter.sv
// canvas_port_arbiter
//   Owns port A (read/write) of the 1024x1 small canvas RAM. The port is shared
//   between three users:
//   - the mouse-drawing writer
//   - the recognizer's read-out sweep
//   - an internal sweeper that zeroes the canvas once a result is committed.
//   The VGA read port of the RAM is not routed through here.
//
// State table
//   IDLE  | mouse owns the port; a buffered write drains first
//   READ  | recognizer owns the port; mouse writes are parked in the hold buffer
//   CLEAR | sweeper writes CLEAR_VAL to every cell, one per cycle
//
// Ports
//   clk, rst                    system clock, synchronous active-high reset
//   wr_req, wr_addr, wr_data    mouse write strobe, one cycle per pixel
//   wr_overflow                 sticky: a parked mouse write was overwritten
//   rd_req, rd_gnt              recognizer ownership request / grant
//   rd_addr, rd_data            recognizer read address / cell value (from ram_q)
//   clear_start                 one-cycle request to clear the canvas
//   clear_busy, clear_done      clear pending-or-running / last-cell pulse
//   ram_addr, ram_d, ram_we     to small_canvas a / d / we
//   ram_q                       from small_canvas spo
module canvas_port_arbiter #(
  parameter int   ADDR_W    = 10,
  parameter int   DEPTH     = 1024,
  parameter logic CLEAR_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_overflow,
  input  logic              rd_req,
  output logic              rd_gnt,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_d,
  output logic              ram_we,
  input  logic              ram_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Terminal count is an explicit compare; the counter is never allowed to
  // rely on natural wrap-around.
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;

  logic              hb_valid;
  logic [ADDR_W-1:0] hb_addr;
  logic              hb_data;

  logic              clear_pending;
  logic              clear_pending_nxt;
  logic [ADDR_W-1:0] sweep_cnt;

  logic              sweep_last;
  logic              hb_drain;
  logic              hb_store;
  logic              clear_accept;
  logic              enter_clear;
  logic              we_int;

  assign sweep_last   = (state == CLEAR) && (sweep_cnt == LAST_CELL);
  assign hb_drain     = (state == IDLE) && hb_valid;

  // A mouse write is parked when the port belongs to the recognizer, or when
  // an older parked write is using the port this cycle. Writes that arrive
  // during CLEAR are dropped: they would only be wiped by the sweep.
  assign hb_store     = wr_req && ((state == READ) || hb_drain);

  // A second clear request while one is pending or running adds nothing.
  assign clear_accept = clear_start && !clear_pending && (state != CLEAR);
  assign enter_clear  = (state_nxt == CLEAR) && (state != CLEAR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_pending) begin
          state_nxt = CLEAR;
        end else if (rd_req) begin
          state_nxt = READ;
        end
      end
      READ: begin
        // A read sweep is never preempted; a pending clear waits for it.
        if (!rd_req) begin
          state_nxt = clear_pending ? CLEAR : IDLE;
        end
      end
      CLEAR: begin
        if (sweep_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clear_pending_nxt = clear_pending;
    if (enter_clear) begin
      clear_pending_nxt = 1'b0;
    end else if (clear_accept) begin
      clear_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_gnt        <= 1'b0;
      clear_busy    <= 1'b0;
      clear_done    <= 1'b0;
      clear_pending <= 1'b0;
      wr_overflow   <= 1'b0;
      hb_valid      <= 1'b0;
      hb_addr       <= '0;
      hb_data       <= 1'b0;
      sweep_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      rd_gnt        <= (state_nxt == READ);
      clear_pending <= clear_pending_nxt;
      clear_busy    <= clear_pending_nxt || (state_nxt == CLEAR);
      clear_done    <= sweep_last;

      // The counter is held at zero outside CLEAR, so every sweep starts at
      // cell 0.
      if ((state != CLEAR) || sweep_last) begin
        sweep_cnt <= '0;
      end else begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end

      // Overwriting a parked write that is not leaving this cycle loses a
      // pixel, which is what the sticky flag records.
      if (hb_store && hb_valid && !hb_drain) begin
        wr_overflow <= 1'b1;
      end

      // A clear wipes the canvas anyway, so parked writes are simply dropped
      // and do not count as overflow.
      if ((state_nxt == CLEAR) || (state == CLEAR)) begin
        hb_valid <= 1'b0;
      end else if (hb_store) begin
        hb_valid <= 1'b1;
        hb_addr  <= wr_addr;
        hb_data  <= wr_data;
      end else if (hb_drain) begin
        hb_valid <= 1'b0;
      end
    end
  end

  // Port mux. The mouse path adds no latency when the buffer is empty.
  always_comb begin
    we_int   = 1'b0;
    ram_addr = wr_addr;
    ram_d    = wr_data;
    case (state)
      IDLE: begin
        if (hb_valid) begin
          we_int   = 1'b1;
          ram_addr = hb_addr;
          ram_d    = hb_data;
        end else if (wr_req) begin
          we_int   = 1'b1;
        end
      end
      READ: begin
        ram_addr = rd_addr;
        ram_d    = CLEAR_VAL;
      end
      CLEAR: begin
        we_int   = 1'b1;
        ram_addr = sweep_cnt;
        ram_d    = CLEAR_VAL;
      end
      default: begin
        we_int   = 1'b0;
      end
    endcase
  end

  // Writes are suppressed in the cycle rst is sampled, so a reset during a
  // sweep stops the RAM writes immediately.
  assign ram_we  = we_int && !rst;
  assign rd_data = ram_q;

endmodule

// File: doc/canvas_port_arbiter.md
Name: canvas_port_arbiter

Overview:
- Owns the single read/write port (port A) of the 1024x1-bit small canvas RAM.
- Shares that port between three users: the mouse-drawing writer, the recognizer's read-out sweep, and an internal clear sweeper that zeroes the canvas once a recognition result is committed.
- Sits between mouse_input, recognizer and small_canvas, and replaces the ad-hoc address/write-enable mux.
- The VGA read port (dpra) is not touched.

Parameters:
- ADDR_W, 10, canvas address width; one address per pixel, {y[4:0], x[4:0]}.
- DEPTH, 1024, number of canvas cells swept by a clear. Must equal 2**ADDR_W.
- CLEAR_VAL, 1'b0, value written to every cell during a clear.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  synchronous reset, active-high.
- wr_req  in  1  mouse write strobe, one cycle per pixel.
- wr_addr  in  ADDR_W  mouse write address.
- wr_data  in  1  mouse write data.
- wr_overflow  out  1  sticky flag: a buffered mouse write was overwritten before it drained. Cleared only by rst.
- rd_req  in  1  recognizer ownership request. Held high for the whole read sweep.
- rd_gnt  out  1  recognizer owns the port.
- rd_addr  in  ADDR_W  recognizer read address.
- rd_data  out  1  canvas cell at rd_addr. Combinational from ram_q.
- clear_start  in  1  one-cycle request to clear the canvas.
- clear_busy  out  1  clear sweep in progress or pending.
- clear_done  out  1  one-cycle pulse after the last cell is written.
- ram_addr  out  ADDR_W  to small_canvas a.
- ram_d  out  1  to small_canvas d.
- ram_we  out  1  to small_canvas we.
- ram_q  in  1  from small_canvas spo.

Behaviour:
- State machine has three states: IDLE (mouse owns the port), READ (recognizer owns it), CLEAR (sweeper owns it). The state is registered. ram_addr, ram_d and ram_we are combinational from state and inputs.
- Reset: state=IDLE; rd_gnt=0; clear_busy=0; clear_done=0; wr_overflow=0; hold buffer empty; clear_pending=0; sweep counter=0.
- Hold buffer:
  - One entry: {valid, addr, data}.
  - A wr_req arriving in any state while the port is unavailable, or while the hold buffer is valid, is stored in the buffer (latest wins).
  - If a write is stored while the buffer is already valid and the old entry is not draining that same cycle, wr_overflow is set.
- IDLE:
  - If the hold buffer is valid, it drains this cycle (ram_we=1, ram_addr/ram_d from the buffer). A simultaneous wr_req goes into the buffer.
  - Otherwise a wr_req drives the port directly (ram_we=1, zero added latency).
  - With no write activity: ram_we=0, ram_addr=wr_addr.
- clear_start handling: sets clear_pending and clear_busy in the next cycle, in any state. A clear_start while already pending or in CLEAR is ignored.
- Transition priority out of IDLE, evaluated each cycle: clear_pending -> CLEAR; else rd_req -> READ.
  - rd_gnt rises one cycle after rd_req is seen in IDLE.
  - A hold-buffer drain that cycle still completes before the transition takes effect.
- READ:
  - ram_we=0; ram_addr=rd_addr; rd_data=ram_q.
  - Mouse writes go to the hold buffer.
  - READ is not preemptible; a clear_start stays pending.
  - When rd_req falls: the next state is CLEAR if clear_pending, else IDLE. rd_gnt falls in the same cycle the state leaves READ.
- CLEAR:
  - Entry clears clear_pending and resets the counter to 0. The hold buffer is discarded, without setting overflow.
  - Each cycle: ram_we=1, ram_addr=counter, ram_d=CLEAR_VAL, counter+1.
  - At counter==DEPTH-1: write the last cell, pulse clear_done for one cycle, go to IDLE, and drop clear_busy together with the state change.
  - Sweep length is exactly DEPTH cycles.
  - Mouse writes during CLEAR are discarded, not buffered, because drawing stays blocked while the recognizer is pending.
  - rd_req during CLEAR is serviced after the sweep completes.
- rd_data is driven from ram_q in all states; it is meaningful only while rd_gnt=1.
- Counter width is ADDR_W. Terminal detection compares against DEPTH-1 and does not rely on wrap-around.
- rst mid-operation (any state, including mid-sweep) returns to the reset values on the next edge. No further RAM writes occur after rst is sampled.

Test Plan:
- Mouse direct write: in IDLE, wr_req with addr=10'h123, data=1 -> same-cycle ram_we=1, ram_addr=10'h123, ram_d=1; wr_overflow stays 0.
- Read grant and buffering: rd_req high at cycle 0 -> rd_gnt=1 at cycle 1; rd_addr=10'h05 gives ram_addr=10'h05 and rd_data=ram_q. Then wr_req addr=10'h3FF during READ -> ram_we=0. Drop rd_req -> the buffered write drains in the first IDLE cycle.
- Overflow: two wr_req pulses (10'h001, then 10'h002) during READ -> wr_overflow=1; only 10'h002 is written after release.
- Full clear: clear_start in IDLE -> clear_busy=1 next cycle; exactly 1024 consecutive writes of 0 at addresses 0..1023; clear_done pulses one cycle on the cycle after the write to 1023; the state is back in IDLE.
- Clear deferred by read: clear_start while rd_gnt=1 -> no RAM writes until rd_req falls; CLEAR starts immediately after READ with no IDLE cycle; a rd_req asserted mid-sweep gets rd_gnt only after clear_done.
- Reset mid-sweep: rst asserted at counter=500 -> next cycle ram_we=0, clear_busy=0, state=IDLE, wr_overflow=0; no clear_done pulse.
